chooser_table_update: RTL and testbench

//  Hybrid chooser table: the update-side consumer of the chooser pipeline.
//  - Predict side: reads a per-PC saturating chooser counter for the fetch PC.

---
 rtl/chooser_table_update_pkg.sv | 18 +
 rtl/chooser_table_update_if.sv | 34 +++
 rtl/chooser_table_update_counter_next.sv | 30 +++
 rtl/chooser_table_update.sv | 121 ++++++++++++
 tb/tb_chooser_table_update.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/chooser_table_update_pkg.sv
// Shared types and defaults for the hybrid chooser table.
package bp_chooser_pkg;

    localparam int CHOOSER_INDEX_BITS = 14;
    localparam int CHOOSER_WIDTH      = 2;

    typedef logic [CHOOSER_WIDTH:1]        chooser_cnt_t;
    typedef logic [CHOOSER_INDEX_BITS-1:0] chooser_idx_t;

    // INIT sweeps the table after reset; READY serves lookups and updates.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } chooser_state_e;

    localparam chooser_cnt_t CHOOSER_INIT_VALUE = 2'd3;

endpackage

// File: rtl/chooser_table_update_if.sv
// Lookup and update signal bundle between the front end and the chooser table.
interface chooser_table_update_if
    import bp_chooser_pkg::*;
#(
    parameter int WIDTH_COUNTER = CHOOSER_WIDTH
);
    // Predict side
    logic                     stall;
    logic [31:0]              PC_lookup;
    logic [WIDTH_COUNTER-1:0] chooser_counter;
    logic                     chooser_valid;
    // Update side
    logic                     update_en;
    logic [31:0]              PC_predict_update;
    logic [WIDTH_COUNTER-1:0] chooser_counter_update;
    logic                     prediction_BATAGE_update;
    logic                     prediction_BFNP_update;
    logic                     branch_direction;
    // Status
    logic                     init_busy;

    modport master (
        output stall, PC_lookup, update_en, PC_predict_update, chooser_counter_update,
               prediction_BATAGE_update, prediction_BFNP_update, branch_direction,
        input  chooser_counter, chooser_valid, init_busy
    );

    modport slave (
        input  stall, PC_lookup, update_en, PC_predict_update, chooser_counter_update,
               prediction_BATAGE_update, prediction_BFNP_update, branch_direction,
        output chooser_counter, chooser_valid, init_busy
    );

endinterface

// File: rtl/chooser_table_update_counter_next.sv
// Next chooser counter value from the predict-time snapshot and the resolved outcome.
// The counter moves toward BFNP when only BFNP was right, toward BATAGE when only
// BATAGE was right, and stays put when both components agreed.
module chooser_counter_next #(
    parameter int W = 2
) (
    input  logic [W-1:0] cnt,
    input  logic         batage,
    input  logic         bfnp,
    input  logic         dir,
    output logic [W-1:0] next
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Saturating step selected by which component predicted correctly.
    // NOTE: the output is assigned a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next = cnt;
        if (batage != bfnp) begin
            if (bfnp == dir) begin
                if (cnt != CNT_MAX) next = cnt + W'(1);
            end else begin
                if (cnt != '0) next = cnt - W'(1);
            end
        end
    end

endmodule

// File: rtl/chooser_table_update.sv
// Per-PC chooser counter table: registered lookup on the predict side, snapshot-based
// write-back on the update side, and a self-clearing sweep after reset.
module chooser_table_update
    import bp_chooser_pkg::*;
#(
    parameter int                       INDEX_BITS    = CHOOSER_INDEX_BITS,
    parameter int                       WIDTH_COUNTER = CHOOSER_WIDTH,
    parameter logic [WIDTH_COUNTER-1:0] INIT_VALUE    = CHOOSER_INIT_VALUE
) (
    input  logic                 clk,
    input  logic                 rst,
    chooser_table_update_if.slave bus
);

    localparam int                  TABLE_DEPTH = 2 ** INDEX_BITS;
    // init_ptr is one bit wider than the index so the sweep never aliases back to 0.
    localparam logic [INDEX_BITS:0] LAST_PTR    = (INDEX_BITS + 1)'(TABLE_DEPTH - 1);

    typedef logic [WIDTH_COUNTER-1:0] cnt_t;
    typedef logic [INDEX_BITS-1:0]    idx_t;

    cnt_t                r_table [TABLE_DEPTH];
    chooser_state_e      r_state;
    chooser_state_e      w_state_next;
    logic [INDEX_BITS:0] r_init_ptr;
    cnt_t                r_counter;
    logic                r_valid;

    idx_t w_lookup_idx;
    idx_t w_update_idx;
    idx_t w_wr_idx;
    cnt_t w_wr_data;
    cnt_t w_update_next;
    logic w_wr_en;
    logic w_update_fire;
    logic w_bypass;
    logic w_in_init;
    logic w_unused;

    assign w_lookup_idx = bus.PC_lookup[INDEX_BITS+2:3];
    assign w_update_idx = bus.PC_predict_update[INDEX_BITS+2:3];

    // PC bits outside the index slice are intentionally ignored.
    assign w_unused = ^{bus.PC_lookup[31:INDEX_BITS+3], bus.PC_lookup[2:0],
                        bus.PC_predict_update[31:INDEX_BITS+3], bus.PC_predict_update[2:0]};

    chooser_counter_next #(
        .W (WIDTH_COUNTER)
    ) u_counter_next (
        .cnt    (bus.chooser_counter_update),
        .batage (bus.prediction_BATAGE_update),
        .bfnp   (bus.prediction_BFNP_update),
        .dir    (bus.branch_direction),
        .next   (w_update_next)
    );

    // State register; reset always restarts the sweep.
    // NOTE: clocked state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= INIT;
        else     r_state <= w_state_next;
    end

    // Next state and the single write-port mux: the sweep pointer in INIT, the update index in READY.
    always_comb begin
        w_state_next  = r_state;
        w_in_init     = 1'b0;
        w_update_fire = 1'b0;
        w_wr_en       = 1'b0;
        w_wr_idx      = w_update_idx;
        w_wr_data     = w_update_next;
        case (r_state)
            INIT: begin
                w_in_init = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_idx  = r_init_ptr[INDEX_BITS-1:0];
                w_wr_data = INIT_VALUE;
                if (r_init_ptr == LAST_PTR) w_state_next = READY;
            end
            READY: begin
                // Updates arriving during INIT fall through here as dropped.
                w_update_fire = bus.update_en;
                w_wr_en       = bus.update_en;
            end
            default: w_state_next = INIT;
        endcase
    end

    // Sweep pointer advances once per INIT cycle.
    always_ff @(posedge clk) begin
        if (rst)                  r_init_ptr <= '0;
        else if (r_state == INIT) r_init_ptr <= r_init_ptr + (INDEX_BITS + 1)'(1);
    end

    // Table write port.
    // NOTE: the array has no reset of its own; the INIT sweep clears it, which keeps
    // it mappable onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) r_table[w_wr_idx] <= w_wr_data;
    end

    // A same-index update in this cycle wins over the stale table contents.
    assign w_bypass = w_update_fire && (w_update_idx == w_lookup_idx);

    // Registered lookup output, held while stalled and pinned during INIT.
    always_ff @(posedge clk) begin
        if (rst || r_state == INIT) begin
            r_counter <= INIT_VALUE;
            r_valid   <= 1'b0;
        end else if (!bus.stall) begin
            r_counter <= w_bypass ? w_update_next : r_table[w_lookup_idx];
            r_valid   <= 1'b1;
        end
    end

    assign bus.chooser_counter = r_counter;
    assign bus.chooser_valid   = r_valid;
    assign bus.init_busy       = rst || w_in_init;

endmodule

// File: tb/tb_chooser_table_update.sv
// Self-checking bench for chooser_table_update: a table-level model checked every
// cycle plus directed vectors with literal expectations.
module tb_chooser_table_update;
    import bp_chooser_pkg::*;

    localparam int D = 1 << CHOOSER_INDEX_BITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chooser_table_update_if dut_if ();

    chooser_table_update dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          init_left = 0;
    logic [1:0]  m_table [D];
    logic [1:0]  m_cnt;
    logic        m_valid;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 3) & 32'(D - 1));
    endfunction

    // Counter moves one step toward whichever component alone was right, clamped to 0..3.
    function automatic int f_model(input int cnt, input bit bat, input bit bfnp, input bit dir);
        int r;
        if (bat == bfnp) return cnt;
        r = cnt + ((bfnp == dir) ? 1 : -1);
        if (r > 3) r = 3;
        if (r < 0) r = 0;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            init_left = D;
            foreach (m_table[i]) m_table[i] = 2'd3;
            m_cnt   = 2'd3;
            m_valid = 1'b0;
        end else if (init_left != 0) begin
            init_left--;
            m_cnt   = 2'd3;
            m_valid = 1'b0;
        end else begin
            if (dut_if.update_en)
                m_table[idx_of(dut_if.PC_predict_update)] =
                    2'(f_model(int'(dut_if.chooser_counter_update), dut_if.prediction_BATAGE_update,
                               dut_if.prediction_BFNP_update, dut_if.branch_direction));
            if (!dut_if.stall) begin
                m_cnt   = m_table[idx_of(dut_if.PC_lookup)];
                m_valid = 1'b1;
            end
        end
    end

    // Compare on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_busy", dut_if.init_busy, (rst || init_left != 0) ? 1 : 0);
            check("model_counter", dut_if.chooser_counter, m_cnt);
            check("model_valid", dut_if.chooser_valid, m_valid);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        dut_if.PC_lookup = pc;
    endtask

    task automatic set_update(input logic [31:0] pc, input logic [1:0] cnt,
                              input bit bat, input bit bfnp, input bit dir);
        dut_if.update_en                = 1'b1;
        dut_if.PC_predict_update        = pc;
        dut_if.chooser_counter_update   = cnt;
        dut_if.prediction_BATAGE_update = bat;
        dut_if.prediction_BFNP_update   = bfnp;
        dut_if.branch_direction         = dir;
    endtask

    task automatic clear_update();
        dut_if.update_en = 1'b0;
    endtask

    // Counts cycles until init_busy drops, bounded so a stuck DUT still ends the run.
    task automatic count_busy(output int n);
        n = 0;
        while (n < D + 50 && dut_if.init_busy === 1'b1) begin
            tick();
            n++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] pcs [5];
        int n;

        dut_if.stall = 1'b0;
        dut_if.PC_lookup = 32'h0;
        clear_update();
        dut_if.PC_predict_update = 32'h0;
        dut_if.chooser_counter_update = 2'd0;
        dut_if.prediction_BATAGE_update = 1'b0;
        dut_if.prediction_BFNP_update = 1'b0;
        dut_if.branch_direction = 1'b0;

        // 1: one reset cycle, then a full sweep of TABLE_DEPTH cycles.
        rst = 1'b1;
        tick();
        check("reset_counter", dut_if.chooser_counter, 3);
        check("reset_valid", dut_if.chooser_valid, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        check("init_busy_start", dut_if.init_busy, 1);
        count_busy(n);
        check("init_len", n, D);

        pcs = '{32'h0, 32'h40, 32'h1_FFF8, 32'hFFFF_FFFC, 32'h1234_5678};
        for (int i = 0; i < 5; i++) begin
            lookup(pcs[i]);
            tick();
            check("post_init_cnt", dut_if.chooser_counter, 3);
            check("post_init_valid", dut_if.chooser_valid, 1);
        end

        // 2: BFNP-only correct saturates at 3; BATAGE-only correct saturates at 0.
        lookup(32'h0);
        set_update(32'h40, 2'd2, 1'b0, 1'b1, 1'b1);
        tick();
        clear_update();
        lookup(32'h40);
        tick();
        check("upd_inc_sat", dut_if.chooser_counter, 3);
        lookup(32'h0);
        set_update(32'h40, 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        clear_update();
        lookup(32'h40);
        tick();
        check("upd_dec_sat", dut_if.chooser_counter, 0);

        // 3: both wrong -> snapshot written unchanged, regardless of stored 3.
        lookup(32'h0);
        set_update(32'h100, 2'd1, 1'b1, 1'b1, 1'b0);
        tick();
        clear_update();
        lookup(32'h100);
        tick();
        check("both_agree", dut_if.chooser_counter, 1);

        // 4: write-first bypass on same index; old contents on a different index.
        lookup(32'h80);
        set_update(32'h80, 2'd1, 1'b0, 1'b1, 1'b1);
        tick();
        clear_update();
        check("bypass", dut_if.chooser_counter, 2);
        lookup(32'h40);
        set_update(32'h88, 2'd0, 1'b0, 1'b1, 1'b1);
        tick();
        clear_update();
        check("diff_idx_old", dut_if.chooser_counter, 0);
        lookup(32'h88);
        tick();
        check("diff_idx_written", dut_if.chooser_counter, 1);

        // Back-to-back updates to one index: the second one sticks.
        lookup(32'h0);
        set_update(32'h200, 2'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_update(32'h200, 2'd1, 1'b1, 1'b0, 1'b1);
        tick();
        clear_update();
        lookup(32'h200);
        tick();
        check("b2b_last", dut_if.chooser_counter, 0);

        // 6: stall holds the output for 3 cycles while PC_lookup moves.
        lookup(32'h80);
        tick();
        check("pre_stall_cnt", dut_if.chooser_counter, 2);
        dut_if.stall = 1'b1;
        pcs = '{32'h40, 32'h100, 32'h88, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            lookup(pcs[i]);
            tick();
            check("stall_cnt", dut_if.chooser_counter, 2);
            check("stall_valid", dut_if.chooser_valid, 1);
        end
        dut_if.stall = 1'b0;
        lookup(32'h100);
        tick();
        check("post_stall_cnt", dut_if.chooser_counter, 1);

        // 5: reset, 100 INIT cycles with update pulses, reset again mid-sweep.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i % 10 == 0) set_update(32'h40, 2'd0, 1'b0, 1'b1, 1'b1);
            else             clear_update();
            lookup(32'(i) << 3);
            tick();
        end
        clear_update();
        check("busy_mid_init", dut_if.init_busy, 1);
        check("valid_mid_init", dut_if.chooser_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_update(32'h80, 2'd0, 1'b0, 1'b1, 1'b1);
        count_busy(n);
        clear_update();
        check("reinit_len", n, D);

        pcs = '{32'h40, 32'h80, 32'h88, 32'h200, 32'h100};
        for (int i = 0; i < 5; i++) begin
            lookup(pcs[i]);
            tick();
            check("reinit_cnt", dut_if.chooser_counter, 3);
        end

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
